// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery sequencing controller.
package mont_pkg;

    localparam int unsigned MONT_N           = 512;
    localparam int unsigned MONT_MAX_RESOLVE = 16;

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_M    = 2'd2;
    localparam logic [1:0] SEL_BM   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ITER  = 3'd2,
        ST_RES1  = 3'd3,
        ST_SUB   = 3'd4,
        ST_RES2  = 3'd5,
        ST_CHECK = 3'd6,
        ST_DONE  = 3'd7
    } mont_state_t;

    typedef struct packed {
        logic       clr_acc;
        logic [1:0] in_sel;
        logic       enable_c;
        logic       shift;
        logic       subtract;
    } mont_ctl_t;

    // Fixed per-state mpadder strobes; ITER select bits are patched in by the caller.
    function automatic mont_ctl_t state_strobes(mont_state_t st);
        mont_ctl_t c;
        c = '0;
        case (st)
            ST_LOAD: begin
                c.clr_acc = 1'b1;
                c.in_sel  = SEL_ZERO;
            end
            ST_ITER: begin
                c.enable_c = 1'b1;
                c.shift    = 1'b1;
            end
            ST_SUB: begin
                c.in_sel   = SEL_M;
                c.enable_c = 1'b1;
                c.subtract = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mont_ctrl.sv
// Montgomery multiply sequencer: scans A bit-serially, drives every mpadder control,
// resolves carries, performs the final conditional subtraction and reports completion.
module mont_ctrl
    import mont_pkg::*;
#(
    parameter int unsigned N           = MONT_N,
    parameter int unsigned MAX_RESOLVE = MONT_MAX_RESOLVE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic         b0,
    input  logic         acc_lsb,
    input  logic         c_zero,
    input  logic         sign,
    output logic         clr_acc,
    output logic [1:0]   in_sel,
    output logic         enable_c,
    output logic         shift,
    output logic         subtract,
    output logic         busy,
    output logic         done,
    output logic         use_sub,
    output logic         error
);

    localparam int unsigned IW = $clog2(N + 1);
    localparam int unsigned TW = $clog2(MAX_RESOLVE + 1);
    localparam logic [IW-1:0] I_LAST = IW'(N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(MAX_RESOLVE - 1);

    mont_state_t   state_q, state_d;
    logic [N-1:0]  a_sr_q, a_sr_d;
    logic          b0_q, b0_d;
    logic [IW-1:0] i_q, i_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_expired_c;
    mont_ctl_t     ctl_q, ctl_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          use_sub_q, use_sub_d;
    logic          error_q, error_d;
    logic          iter_c;
    logic          q_c;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_ITER;
            ST_ITER: begin
                if (i_q == I_LAST) begin
                    state_d = ST_RES1;
                end
            end
            ST_RES1: begin
                if (c_zero) begin
                    state_d = ST_SUB;
                end else if (tmo_expired_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_SUB: state_d = ST_RES2;
            ST_RES2: begin
                if (c_zero) begin
                    state_d = ST_CHECK;
                end else if (tmo_expired_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Shared carry-resolution timeout; idles at zero so each resolve phase starts fresh.
    always_comb begin
        tmo_d         = '0;
        tmo_expired_c = 1'b0;
        if (state_q == ST_RES1 || state_q == ST_RES2) begin
            tmo_expired_c = (tmo_q == T_LAST);
            tmo_d         = tmo_q + TW'(1);
        end
    end

    // Operand shift register, bit counter and sticky status.
    always_comb begin
        a_sr_d    = a_sr_q;
        b0_d      = b0_q;
        i_d       = i_q;
        use_sub_d = use_sub_q;
        error_d   = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d    = a_in;
                    b0_d      = b0;
                    use_sub_d = 1'b0;
                    error_d   = 1'b0;
                end
            end
            ST_LOAD: i_d = '0;
            ST_ITER: begin
                a_sr_d = a_sr_q >> 1;
                i_d    = i_q + IW'(1);
            end
            ST_RES1, ST_RES2: begin
                if (!c_zero && tmo_expired_c) begin
                    error_d = 1'b1;
                end
            end
            ST_CHECK: use_sub_d = ~sign;
            default: begin
                a_sr_d = a_sr_q;
            end
        endcase
    end

    // Output decode of the upcoming state, registered alongside it.
    always_comb begin
        ctl_d = state_strobes(state_d);
        if (state_d == ST_ITER) begin
            ctl_d.in_sel = {1'b0, a_sr_d[0]};
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr_q    <= '0;
            b0_q      <= 1'b0;
            i_q       <= '0;
            tmo_q     <= '0;
            ctl_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            use_sub_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            a_sr_q    <= a_sr_d;
            b0_q      <= b0_d;
            i_q       <= i_d;
            tmo_q     <= tmo_d;
            ctl_q     <= ctl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            use_sub_q <= use_sub_d;
            error_q   <= error_d;
        end
    end

    // Quotient bit depends on this cycle's resolved accumulator LSB, so it bypasses the flops.
    assign iter_c = (state_q == ST_ITER);
    assign q_c    = acc_lsb ^ (a_sr_q[0] & b0_q);

    assign clr_acc  = ctl_q.clr_acc;
    assign in_sel   = {ctl_q.in_sel[1] | (iter_c & q_c), ctl_q.in_sel[0]};
    assign enable_c = ctl_q.enable_c;
    assign shift    = ctl_q.shift;
    assign subtract = ctl_q.subtract;
    assign busy     = busy_q;
    assign done     = done_q;
    assign use_sub  = use_sub_q;
    assign error    = error_q;

endmodule

// File: tb/tb_mont_ctrl.sv
// Directed bench for mont_ctrl at N = 8 with a behavioural accumulator standing in for mpadder.
module tb_mont_ctrl;

    localparam int unsigned N    = 8;
    localparam int unsigned MAXR = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a_in;
    logic         b0;
    logic         acc_lsb;
    logic         c_zero;
    logic         sign;
    logic         clr_acc;
    logic [1:0]   in_sel;
    logic         enable_c;
    logic         shift;
    logic         subtract;
    logic         busy;
    logic         done;
    logic         use_sub;
    logic         error;

    int n_checks = 0;
    int n_pass   = 0;

    int acc     = 0;
    int acc_pre = 0;
    int op_b    = 0;
    int op_m    = 0;
    bit force_en  = 1'b0;
    bit force_val = 1'b0;

    int    lat;
    int    res;
    logic  us;
    logic  er;
    bit    sub_seen;

    mont_ctrl #(.N(N), .MAX_RESOLVE(MAXR)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b0       (b0),
        .acc_lsb  (acc_lsb),
        .c_zero   (c_zero),
        .sign     (sign),
        .clr_acc  (clr_acc),
        .in_sel   (in_sel),
        .enable_c (enable_c),
        .shift    (shift),
        .subtract (subtract),
        .busy     (busy),
        .done     (done),
        .use_sub  (use_sub),
        .error    (error)
    );

    always #5 clk = ~clk;

    assign acc_lsb = force_en ? force_val : acc[0];
    assign sign    = (acc < 0);

    function automatic int sel_op(logic [1:0] s);
        case (s)
            2'd1:    return op_b;
            2'd2:    return op_m;
            2'd3:    return op_b + op_m;
            default: return 0;
        endcase
    endfunction

    // Behavioural mpadder + fully resolved accumulator.
    always @(posedge clk) begin
        if (clr_acc) begin
            acc <= 0;
        end else if (enable_c && subtract) begin
            acc_pre <= acc;
            acc     <= acc - op_m;
        end else if (enable_c) begin
            if (shift) acc <= (acc + sel_op(in_sel)) >>> 1;
            else       acc <= acc + sel_op(in_sel);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [9:0] outs();
        return {clr_acc, in_sel, enable_c, shift, subtract, busy, done, use_sub, error};
    endfunction

    function automatic logic [7:0] trace_now();
        return {clr_acc, in_sel, enable_c, shift, subtract, busy, done};
    endfunction

    // Hand-derived trace for A=5, B=7, M=11, one-cycle resolves; k=0 is LOAD.
    function automatic logic [7:0] exp_trace(int k);
        logic [1:0] s;
        case (k)
            1, 3:    s = 2'd3;
            4, 7:    s = 2'd0;
            default: s = 2'd2;
        endcase
        if (k == 0)  return 8'b1_00_0_0_0_1_0;
        if (k <= 8)  return {1'b0, s, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        if (k == 10) return 8'b0_10_1_0_1_1_0;
        if (k == 13) return 8'b0_00_0_0_0_1_1;
        return 8'b0_00_0_0_0_1_0;
    endfunction

    task automatic wait_done(input string tag);
        for (int k = 0; k < 100 && done !== 1'b1; k++) @(negedge clk);
        check(tag, done, 1);
        @(negedge clk);
    endtask

    // One operation from start; lat counts cycles from LOAD through the done cycle inclusive.
    task automatic do_op(input logic [N-1:0] a, input int b, input int m,
                         input bit use_trace, input int inject_k, input int abort_k,
                         input bit start_in_done,
                         output int lat_o, output int res_o, output logic us_o,
                         output logic er_o, output bit sub_o);
        lat_o = -1;
        res_o = -1;
        us_o  = 1'bx;
        er_o  = 1'bx;
        sub_o = 1'b0;
        @(negedge clk);
        a_in  = a;
        b0    = b[0];
        op_b  = b;
        op_m  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (use_trace) check($sformatf("trace_k%0d", k), trace_now(), exp_trace(k));
            if (subtract) sub_o = 1'b1;
            start = (k == inject_k);
            if (k == abort_k) begin
                reset = 1'b1;
                return;
            end
            if (done === 1'b1) begin
                lat_o = k + 1;
                us_o  = use_sub;
                er_o  = error;
                res_o = use_sub ? acc : acc_pre;
                break;
            end
            @(negedge clk);
        end
        if (lat_o < 0) begin
            check("done_within_bound", done, 1);
            start = 1'b0;
            return;
        end
        start = start_in_done;
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("busy_after_done", busy, 0);
        if (start_in_done) begin
            @(negedge clk);
            start = 1'b0;
            check("restart_busy", busy, 1);
            check("restart_load", clr_acc, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b0     = 1'b0;
        c_zero = 1'b1;

        // Reset, with a start pulse that must be ignored.
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("reset_outs", outs(), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", outs(), 0);

        // Select sequence with acc_lsb forced low.
        force_en  = 1'b1;
        force_val = 1'b0;
        a_in  = 8'h01;
        b0    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("sel_i0", in_sel, 3);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("sel_i%0d", i), in_sel, 0);
        end
        wait_done("sel_run1_done");

        // acc_lsb forced high: q flips the select combinationally.
        force_val = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("sel_q_i0", in_sel, 1);
        @(negedge clk);
        check("sel_q_i1", in_sel, 2);
        force_val = 1'b0;
        #1;
        check("sel_comb_lo", in_sel, 0);
        force_val = 1'b1;
        #1;
        check("sel_comb_hi", in_sel, 2);
        wait_done("sel_run2_done");
        force_en = 1'b0;

        // End-to-end: 5*7*2^-8 mod 11 = 8, no subtraction taken.
        do_op(8'd5, 7, 11, 1'b1, -1, -1, 1'b0, lat, res, us, er, sub_seen);
        check("e2e_latency", lat, 14);
        check("e2e_result", res, 8);
        check("e2e_use_sub", us, 0);
        check("e2e_error", er, 0);

        // b0 = 0 path: 255*10*2^-8 mod 11 = 3, subtraction taken.
        do_op(8'hFF, 10, 11, 1'b0, -1, -1, 1'b0, lat, res, us, er, sub_seen);
        check("b0z_latency", lat, 14);
        check("b0z_result", res, 3);
        check("b0z_use_sub", us, 1);
        check("use_sub_held", use_sub, 1);

        // Start during ITER ignored: same trace and result.
        do_op(8'd5, 7, 11, 1'b1, 3, -1, 1'b0, lat, res, us, er, sub_seen);
        check("busy_start_latency", lat, 14);
        check("busy_start_result", res, 8);

        // Resolution timeout in RES1.
        c_zero = 1'b0;
        do_op(8'd5, 7, 11, 1'b0, -1, -1, 1'b0, lat, res, us, er, sub_seen);
        c_zero = 1'b1;
        check("tmo_latency", lat, 26);
        check("tmo_error", er, 1);
        check("tmo_no_sub", sub_seen, 0);
        check("error_held", error, 1);

        // Fresh start clears error; start in DONE ignored, start after DONE accepted.
        do_op(8'hFF, 10, 11, 1'b0, -1, -1, 1'b1, lat, res, us, er, sub_seen);
        check("clear_error", er, 0);
        check("sid_result", res, 3);
        wait_done("restart_done");

        // Reset abort at i = 4, then a clean full operation.
        do_op(8'd5, 7, 11, 1'b0, -1, 5, 1'b0, lat, res, us, er, sub_seen);
        @(negedge clk);
        reset = 1'b0;
        check("abort_outs", outs(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort_quiet_%0d", i), {busy, done}, 0);
        end
        do_op(8'd5, 7, 11, 1'b1, -1, -1, 1'b0, lat, res, us, er, sub_seen);
        check("post_abort_latency", lat, 14);
        check("post_abort_result", res, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mont_ctrl.md
# mont_ctrl

Sequencing controller for the 514-bit carry-save `mpadder` in the Montgomery datapath. It computes R = A·B·2^-N mod M by scanning A one bit per cycle and choosing the adder input each cycle. It then resolves the carry-save accumulator, performs the final conditional subtraction of M, and reports completion. It sits between the top-level command interface and the `mpadder` and operand registers. It owns every `mpadder` control input.

## Interface
- `N`, 512: operand width and iteration count.
- `MAX_RESOLVE`, 16: carry-resolution timeout, in cycles.
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request. It is honoured only in IDLE.
- `a_in`  in  N: multiplier A. It is captured on an accepted `start`.
- `b0`  in  1: bit 0 of B. It is captured on an accepted `start`.
- `acc_lsb`  in  1: bit 0 of the resolved accumulator sum, from the datapath.
- `c_zero`  in  1: `mpadder` carry vector is all-zero.
- `sign`  in  1: accumulator MSB, meaning the result is negative after subtraction.
- `clr_acc`  out  1: clears the accumulator and carry registers.
- `in_sel`  out  2: operand mux select: 0 = zero, 1 = B, 2 = M, 3 = B+M (B+M is precomputed by the datapath).
- `enable_c`  out  1: `mpadder` enableC.
- `shift`  out  1: `mpadder` shift (right-shift by 1 after the add).
- `subtract`  out  1: `mpadder` subtract.
- `busy`  out  1: high from an accepted `start` until `done`.
- `done`  out  1: one-cycle completion pulse.
- `use_sub`  out  1: high selects the subtracted result (R − M), low selects the pre-subtraction copy. Valid while `done` = 1 and held until the next `start`.
- `error`  out  1: resolution timeout. Valid with `done` and held until the next `start`.

## Operation
- States: IDLE, LOAD, ITER, RES1, SUB, RES2, CHECK, DONE.
- IDLE
  - All strobes are 0.
  - On `start`: capture `a_in` into shift register `a_sr`, capture `b0`, clear `error`/`use_sub`, set `busy`, go to LOAD.
- LOAD
  - `clr_acc` = 1, `in_sel` = 0, `enable_c` = 0.
  - Go to ITER and set bit counter i = 0.
- ITER (N cycles, i = 0..N−1)
  - Let a = `a_sr[0]`.
  - q = `acc_lsb` XOR (a AND `b0`). M is odd by contract.
  - `in_sel` = {q, a}, `enable_c` = 1, `shift` = 1, `subtract` = 0.
  - `a_sr` shifts right and i increments.
  - After i = N−1, go to RES1 and reset the timeout counter.
- RES1
  - `enable_c` = 0, `shift` = 0.
  - Wait for `c_zero`, then go to SUB.
  - If `MAX_RESOLVE` cycles pass without `c_zero`: `error` = 1, go to DONE.
- SUB (1 cycle)
  - `in_sel` = 2, `subtract` = 1, `enable_c` = 1, `shift` = 0.
  - Go to RES2 and reset the timeout counter.
- RES2
  - Same as RES1, but go to CHECK on `c_zero`.
- CHECK (1 cycle)
  - `use_sub` = NOT `sign`.
  - Go to DONE.
- DONE (1 cycle)
  - `done` = 1, `busy` drops to 0 on the next cycle.
  - Return to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `acc_lsb` is the datapath's resolved sum LSB for the current cycle's accumulator state. The datapath guarantees it combinationally.

## Timing
- Reset (synchronous)
  - State = IDLE.
  - All outputs = 0, including `use_sub` and `error`.
  - `a_sr` and counters = 0.
  - Reset mid-operation aborts immediately. No `done` is generated.
- Outputs are registered state decodes, except `in_sel[1]` in ITER (q), which is combinational from `acc_lsb`.
- Latency from the accepted `start` edge to `done` high is 1 (LOAD) + N + r1 + 1 + r2 + 1 + 1 cycles.
  - r1, r2 are the resolve cycles, each ≥ 1 and ≤ `MAX_RESOLVE`.
  - Minimum for N = 512 is 518.
- `c_zero` already high on entry to RES1/RES2 costs exactly one cycle.
- On timeout, `done` still pulses and `use_sub` is invalid.
- `start` in the DONE cycle is ignored. `start` in the cycle after DONE is accepted.
- Counter widths: $clog2(N+1) for i, $clog2(`MAX_RESOLVE`+1) for the timeout counter.

## Structure
- Package `mont_pkg` holds:
  - the state enum `mont_state_t`;
  - `in_sel` encodings SEL_ZERO, SEL_B, SEL_M, SEL_BM;
  - default `N` and `MAX_RESOLVE`.
- Single module, with no sub-module.
  - The timeout counter is shared by RES1 and RES2.
  - It is inlined as a small always block.

## Test plan
- Reset and ignored start
  - Stimulus: assert `reset` for 3 cycles, then pulse `start` while `reset` = 1.
  - Required: all outputs 0, state stays IDLE, no `busy`.
- Select sequence (N = 8)
  - Stimulus: `a_in` = 8'h01, `b0` = 1, `acc_lsb` = 0.
  - Required: first ITER cycle `in_sel` = 3; remaining 7 ITER cycles `in_sel` = 0.
  - Then force `acc_lsb` = 1 with a = 0: required `in_sel` = 2.
- End-to-end (N = 8, with a behavioural `mpadder` + accumulator model)
  - Stimulus: A = 5, B = 7, M = 11.
  - Required: final selected result = 8, `use_sub` consistent with `sign`, `done` exactly once.
  - Required latency: 14 cycles when `c_zero` resolves in 1 cycle.
- Timeout
  - Stimulus: hold `c_zero` = 0 in RES1.
  - Required: after 16 cycles `error` = 1, `done` pulses, SUB is never entered (`subtract` stays 0).
- Busy start and reset abort
  - Stimulus: pulse `start` during ITER.
  - Required: ignored, with identical output trace.
  - Stimulus: assert `reset` at i = 4.
  - Required: IDLE next cycle, no `done`; a following `start` runs a full, correct operation.
